fp16_div: RTL and testbench

Sequential IEEE-754 binary16 divider (quotient = in1 / in2) for the floating-point datapath. It is the inverse arithmetic companion to the fp16 add/mul units. It accepts one operand pair through a valid/ready handshake and computes the significand quotient with a 13-cycle restoring divider. It rounds to nearest-even and holds the result until the consumer takes it. Only one operation is in flight at a time.

---
 rtl/fp16_div_if.sv | 21 ++
 rtl/fp16_div.sv | 183 ++++++++++++++++++
 tb/tb_fp16_div.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_div_if.sv
// Operand/result handshake bundle for the binary16 divider.
interface fp16_div_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quo;
  logic [3:0]  flags;

  modport master (
    output in_valid, in1, in2, out_ready,
    input  in_ready, out_valid, quo, flags
  );

  modport slave (
    input  in_valid, in1, in2, out_ready,
    output in_ready, out_valid, quo, flags
  );
endinterface

// File: rtl/fp16_div.sv
// Sequential IEEE-754 binary16 divider: 13-step restoring significand divide,
// round-to-nearest-even, subnormals flushed to zero, result held until taken.
module fp16_div (
  input  logic   clk,
  input  logic   rst,
  fp16_div_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

  state_t             state_q;
  logic               in_ready_q, out_valid_q;
  logic [15:0]        quo_q;
  logic [3:0]         flags_q;
  logic               sign_q;
  logic signed [6:0]  exp_q;
  logic [11:0]        rem_q;
  logic [10:0]        dvs_q;
  logic [12:0]        quot_q;
  logic [3:0]         cnt_q;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quo       = quo_q;
  assign bus.flags     = flags_q;

  // Operand classification and special-case resolution at accept
  logic [4:0]        e1, e2;
  logic [9:0]        f1, f2;
  logic              sign_d;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic              special;
  logic [15:0]       spec_quo;
  logic [3:0]        spec_flags;
  logic signed [6:0] exp_d;

  always_comb begin
    e1     = bus.in1[14:10];
    e2     = bus.in2[14:10];
    f1     = bus.in1[9:0];
    f2     = bus.in2[9:0];
    sign_d = bus.in1[15] ^ bus.in2[15];
    a_zero = (e1 == 5'd0);
    b_zero = (e2 == 5'd0);
    a_inf  = (e1 == 5'h1F) && (f1 == '0);
    b_inf  = (e2 == 5'h1F) && (f2 == '0);
    a_nan  = (e1 == 5'h1F) && (f1 != '0);
    b_nan  = (e2 == 5'h1F) && (f2 != '0);
    exp_d  = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 7'sd15;
    special    = 1'b1;
    spec_quo   = '0;
    spec_flags = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_quo   = 16'h7E00;
      spec_flags = 4'b1000;
    end else if (a_inf) begin
      spec_quo = {sign_d, 5'h1F, 10'h000};
    end else if (b_zero) begin
      spec_quo   = {sign_d, 5'h1F, 10'h000};
      spec_flags = 4'b0100;
    end else if (a_zero || b_inf) begin
      spec_quo = {sign_d, 15'h0000};
    end else begin
      special = 1'b0;
    end
  end

  // One restoring step; the remainder after subtraction is below d, so the shift loses nothing
  logic        rem_ge;
  logic [11:0] rem_sub;
  logic [11:0] rem_d;
  logic [12:0] quot_d;

  always_comb begin
    rem_ge  = (rem_q >= {1'b0, dvs_q});
    rem_sub = rem_ge ? (rem_q - {1'b0, dvs_q}) : rem_q;
    rem_d   = {rem_sub[10:0], 1'b0};
    quot_d  = {quot_q[11:0], rem_ge};
  end

  // Normalise, round to nearest-even, then range-check the exponent
  logic              sticky, rbit, rnd_up;
  logic [10:0]       sig;
  logic [11:0]       sig_inc;
  logic [9:0]        frac_rnd;
  logic signed [6:0] exp_rnd;
  logic [15:0]       rnd_quo;
  logic [3:0]        rnd_flags;

  always_comb begin
    sticky = (rem_q != '0);
    if (quot_q[12]) begin
      sig     = quot_q[12:2];
      rbit    = quot_q[1];
      sticky  = sticky | quot_q[0];
      exp_rnd = exp_q;
    end else begin
      sig     = quot_q[11:1];
      rbit    = quot_q[0];
      exp_rnd = exp_q - 7'sd1;
    end
    rnd_up  = rbit & (sticky | sig[0]);
    sig_inc = {1'b0, sig} + {11'b0, rnd_up};
    if (sig_inc[11]) begin
      frac_rnd = '0;
      exp_rnd  = exp_rnd + 7'sd1;
    end else begin
      frac_rnd = sig_inc[9:0];
    end
    rnd_flags = '0;
    if (exp_rnd >= 7'sd31) begin
      rnd_quo   = {sign_q, 5'h1F, 10'h000};
      rnd_flags = 4'b0010;
    end else if (exp_rnd <= 7'sd0) begin
      rnd_quo   = {sign_q, 15'h0000};
      rnd_flags = 4'b0001;
    end else begin
      rnd_quo = {sign_q, exp_rnd[4:0], frac_rnd};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quo_q       <= '0;
      flags_q     <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      quot_q      <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            rem_q      <= {2'b01, f1};
            dvs_q      <= {1'b1, f2};
            quot_q     <= '0;
            cnt_q      <= 4'd12;
            in_ready_q <= 1'b0;
            if (special) begin
              quo_q       <= spec_quo;
              flags_q     <= spec_flags;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          if (cnt_q == 4'd0) begin
            state_q <= ROUND;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ROUND: begin
          quo_q       <= rnd_quo;
          flags_q     <= rnd_flags;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp16_div.sv
// Bench for fp16_div: fixed vectors, backpressure and reset-abort sequences,
// plus random operands against an exact-rational reference model.
module tb_fp16_div;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  fp16_div_if bus ();

  fp16_div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [3:0]  f;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Latency counts the accepting edge as clock 1.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic [3:0] f, output int lat);
    bus.in1      = a;
    bus.in2      = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out(lat);
    q = bus.quo;
    f = bus.flags;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  // Reference: exact integer quotient of the significands, rounded by comparing
  // twice the remainder against the divisor.
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [3:0] f, output int lat);
    int ea, eb, fa, fb, e;
    longint ma, mb, num, sg, rm;
    logic s, za, zb, ia, ib, na, nb;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    za = (ea == 0);  zb = (eb == 0);
    ia = (ea == 31) && (fa == 0);  ib = (eb == 31) && (fb == 0);
    na = (ea == 31) && (fa != 0);  nb = (eb == 31) && (fb != 0);
    f = 4'h0;
    lat = 1;
    if (na || nb || (za && zb) || (ia && ib)) begin
      q = 16'h7E00; f = 4'b1000;
    end else if (ia) begin
      q = {s, 15'h7C00};
    end else if (zb) begin
      q = {s, 15'h7C00}; f = 4'b0100;
    end else if (za || ib) begin
      q = {s, 15'h0000};
    end else begin
      lat = 15;
      ma = 1024 + fa;
      mb = 1024 + fb;
      e  = ea - eb + 15;
      if (ma >= mb) num = ma * 1024;
      else begin
        num = ma * 2048;
        e   = e - 1;
      end
      sg = num / mb;
      rm = num % mb;
      if ((2 * rm > mb) || ((2 * rm == mb) && (sg % 2 == 1))) sg = sg + 1;
      if (sg == 2048) begin
        sg = 1024;
        e  = e + 1;
      end
      if (e >= 31) begin
        q = {s, 15'h7C00}; f = 4'b0010;
      end else if (e <= 0) begin
        q = {s, 15'h0000}; f = 4'b0001;
      end else begin
        q = {s, 5'(e), 10'(sg)};
      end
    end
  endtask

  function automatic logic [15:0] rand_operand();
    logic [4:0] ex;
    logic [9:0] fr;
    logic       sg;
    sg = 1'($urandom);
    fr = 10'($urandom);
    if ($urandom_range(0, 9) == 0) ex = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31;
    else ex = 5'($urandom_range(1, 30));
    if ($urandom_range(0, 7) == 0) fr = '0;
    return {sg, ex, fr};
  endfunction

  initial begin
    vec_t        vecs [11];
    logic [15:0] q, mq;
    logic [3:0]  f, mf;
    int          lat, mlat;

    n_pass  = 0;
    n_total = 0;
    vecs[0]  = '{16'h3C00, 16'h4000, 16'h3800, 4'b0000, 15};
    vecs[1]  = '{16'h3C00, 16'h4200, 16'h3555, 4'b0000, 15};
    vecs[2]  = '{16'h4600, 16'hC000, 16'hC200, 4'b0000, 15};
    vecs[3]  = '{16'h3C00, 16'h0000, 16'h7C00, 4'b0100, 1};
    vecs[4]  = '{16'h0000, 16'h0000, 16'h7E00, 4'b1000, 1};
    vecs[5]  = '{16'h7BFF, 16'h3800, 16'h7C00, 4'b0010, 15};
    vecs[6]  = '{16'h0400, 16'h4000, 16'h0000, 4'b0001, 15};
    vecs[7]  = '{16'hFC00, 16'h4000, 16'hFC00, 4'b0000, 1};
    vecs[8]  = '{16'h7C00, 16'hFC00, 16'h7E00, 4'b1000, 1};
    vecs[9]  = '{16'h0001, 16'h3C00, 16'h0000, 4'b0000, 1};
    vecs[10] = '{16'hBC00, 16'h7C00, 16'h8000, 4'b0000, 1};

    bus.in_valid  = 1'b0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset quo", 32'(bus.quo), 32'h0);
    check("reset flags", 32'(bus.flags), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, q, f, lat);
      check($sformatf("vec%0d quo", i), 32'(q), 32'(vecs[i].q));
      check($sformatf("vec%0d flags", i), 32'(f), 32'(vecs[i].f));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      take();
      check($sformatf("vec%0d in_ready after take", i), 32'(bus.in_ready), 32'd1);
    end

    // Backpressure: result held, new operands wait until the handshake
    run_op(16'h3C00, 16'h4000, q, f, lat);
    bus.in1      = 16'h4600;
    bus.in2      = 16'hC000;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d quo", c), 32'(bus.quo), 32'h3800);
      check($sformatf("bp%0d flags", c), 32'(bus.flags), 32'h0);
      check($sformatf("bp%0d in_ready", c), 32'(bus.in_ready), 32'd0);
      check($sformatf("bp%0d out_valid", c), 32'(bus.out_valid), 32'd1);
    end
    take();
    check("bp release in_ready", 32'(bus.in_ready), 32'd1);
    check("bp release out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp queued accepted", 32'(bus.in_ready), 32'd0);
    wait_out(lat);
    check("bp queued quo", 32'(bus.quo), 32'hC200);
    check("bp queued latency", 32'(lat), 32'd15);
    take();

    // Asynchronous reset during the sixth DIVIDE cycle
    bus.in1      = 16'h4600;
    bus.in2      = 16'h4200;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("abort in_ready", 32'(bus.in_ready), 32'd1);
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    check("abort quo", 32'(bus.quo), 32'h0);
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    run_op(16'h3C00, 16'h4000, q, f, lat);
    check("post-abort quo", 32'(q), 32'h3800);
    check("post-abort flags", 32'(f), 32'h0);
    check("post-abort latency", 32'(lat), 32'd15);
    take();

    // Random operands against the reference model
    for (int i = 0; i < 250; i++) begin
      logic [15:0] a, b;
      a = rand_operand();
      b = rand_operand();
      model(a, b, mq, mf, mlat);
      run_op(a, b, q, f, lat);
      check($sformatf("rnd%0d %h/%h quo", i, a, b), 32'(q), 32'(mq));
      check($sformatf("rnd%0d %h/%h flags", i, a, b), 32'(f), 32'(mf));
      check($sformatf("rnd%0d latency", i), 32'(lat), 32'(mlat));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
      take();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
